// File: rtl/display_frame_writer.sv
// Display RAM refresher: snapshots NDIG digits per frame and writes them top-down
// into the display RAM, with frame pacing, RAM back-pressure and optional write-on-change.
module display_frame_writer #(
    parameter int NDIG      = 8,
    parameter int DIGW      = 4,
    parameter int FRAME_DIV = 1,
    parameter int ON_CHANGE = 0,
    localparam int AW       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NDIG*DIGW-1:0] dig_in,
    input  logic [NDIG-1:0]      dp_in,
    input  logic [NDIG-1:0]      blank_in,
    input  logic                 force_refresh,
    input  logic                 wr_ready,
    output logic                 W,
    output logic [AW-1:0]        WADD,
    output logic [DIGW+1:0]      DIN,
    output logic                 frame_done,
    output logic                 busy
);
    localparam int WW  = DIGW + 2;
    localparam int DVW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [AW-1:0]  LAST_IDX = AW'(NDIG - 1);
    localparam logic [DVW-1:0] DIV_END  = DVW'(FRAME_DIV - 1);

    typedef enum logic [1:0] {IDLE, LATCH, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [DVW-1:0] div, div_nxt;
    logic [AW-1:0]  idx, idx_nxt;
    logic [AW-1:0]  wadd_nxt;
    logic [WW-1:0]  din_nxt;
    logic           w_nxt, fd_nxt;
    logic           cmp_en, cmp_nxt;
    logic           shadow_valid, refresh_pend;

    logic [NDIG*DIGW-1:0] snap_dig;
    logic [NDIG-1:0]      snap_dp, snap_blank;
    logic [WW-1:0]        shadow [NDIG];

    function automatic logic [WW-1:0] word_of(input logic [NDIG*DIGW-1:0] d,
                                              input logic [NDIG-1:0] dp,
                                              input logic [NDIG-1:0] bl,
                                              input logic [AW-1:0] i);
        return {~bl[i], d[int'(i)*DIGW +: DIGW], ~dp[i]};
    endfunction

    // Next slot is computed one cycle ahead so W/WADD/DIN come straight from flops.
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        idx_nxt   = idx;
        cmp_nxt   = cmp_en;
        w_nxt     = 1'b0;
        wadd_nxt  = WADD;
        din_nxt   = DIN;
        fd_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (div == DIV_END) begin
                    div_nxt   = '0;
                    state_nxt = LATCH;
                end else begin
                    div_nxt = div + 1'b1;
                end
            end
            LATCH: begin
                state_nxt = WRITE;
                idx_nxt   = LAST_IDX;
                wadd_nxt  = LAST_IDX;
                din_nxt   = word_of(dig_in, dp_in, blank_in, LAST_IDX);
                cmp_nxt   = shadow_valid && !force_refresh;
                w_nxt     = !((ON_CHANGE != 0) && cmp_nxt && (shadow[LAST_IDX] == din_nxt));
            end
            WRITE: begin
                if (W && !wr_ready) begin
                    w_nxt = 1'b1;
                end else if (idx == '0) begin
                    state_nxt = DONE;
                    fd_nxt    = 1'b1;
                end else begin
                    idx_nxt  = idx - 1'b1;
                    wadd_nxt = idx_nxt;
                    din_nxt  = word_of(snap_dig, snap_dp, snap_blank, idx_nxt);
                    w_nxt    = !((ON_CHANGE != 0) && cmp_en && (shadow[idx_nxt] == din_nxt));
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div        <= '0;
            idx        <= LAST_IDX;
            cmp_en     <= 1'b0;
            W          <= 1'b0;
            WADD       <= LAST_IDX;
            DIN        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            idx        <= idx_nxt;
            cmp_en     <= cmp_nxt;
            W          <= w_nxt;
            WADD       <= wadd_nxt;
            DIN        <= din_nxt;
            frame_done <= fd_nxt;
        end
    end

    // A refresh request keeps the shadow invalid until a whole frame has been rewritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_valid <= 1'b0;
            refresh_pend <= 1'b0;
        end else begin
            if (force_refresh)
                shadow_valid <= 1'b0;
            else if (state == DONE && ON_CHANGE != 0 && !refresh_pend)
                shadow_valid <= 1'b1;
            if (force_refresh)
                refresh_pend <= 1'b1;
            else if (state == LATCH)
                refresh_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == LATCH) begin
            snap_dig   <= dig_in;
            snap_dp    <= dp_in;
            snap_blank <= blank_in;
        end
        if (state == WRITE && W && wr_ready)
            shadow[idx] <= DIN;
    end

    assign busy = (state != IDLE);
endmodule
